// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe
//   Registered, parametrised bitwise gate. NUM_IN operands of WIDTH bits are
//   reduced through a runtime-selected gate. The result is held in a
//   single-stage output register behind a valid/ready handshake. The
//   register also carries all-ones and non-zero flags for the result.
//
// Parameters
//   WIDTH   operand / result width
//   NUM_IN  operand count, 1..8
//   CNT_W   transfer counter width (stats build only)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready = !out_valid || out_ready)
//   in_data               operand k at [k*WIDTH +: WIDTH]
//   in_op                 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 BUF, 7 NOT
//   out_valid / out_ready output handshake
//   out_data              registered result
//   out_all / out_any     registered AND / OR reduction of out_data
//
// Optional build macro LOGIC_GATE_PIPE_STATS_EN adds these ports:
//   count_clr             synchronous clear of xfer_count; it wins over an increment
//   xfer_count            saturating count of completed output transfers
module logic_gate_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_all,
  output logic                    out_any
`ifdef LOGIC_GATE_PIPE_STATS_EN
  ,
  input  logic                    count_clr,
  output logic [CNT_W-1:0]        xfer_count
`endif
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_BUF  = 3'd6,
    OP_NOT  = 3'd7
  } gate_op_e;

  logic [WIDTH-1:0] fold_and;
  logic [WIDTH-1:0] fold_or;
  logic [WIDTH-1:0] fold_xor;
  logic [WIDTH-1:0] result;
  logic             accept;
  logic             consume;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  // Folds run over the operands in index order. The inverting ops apply
  // the inversion once, to the folded value. They are not a chain of
  // inverting gates.
  always_comb begin
    fold_and = in_data[WIDTH-1:0];
    fold_or  = in_data[WIDTH-1:0];
    fold_xor = in_data[WIDTH-1:0];
    for (int unsigned k = 1; k < NUM_IN; k++) begin
      fold_and = fold_and & in_data[k*WIDTH +: WIDTH];
      fold_or  = fold_or  | in_data[k*WIDTH +: WIDTH];
      fold_xor = fold_xor ^ in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    result = '0;
    case (gate_op_e'(in_op))
      OP_AND:  result = fold_and;
      OP_OR:   result = fold_or;
      OP_XOR:  result = fold_xor;
      OP_NAND: result = ~fold_and;
      OP_NOR:  result = ~fold_or;
      OP_XNOR: result = ~fold_xor;
      OP_BUF:  result = in_data[WIDTH-1:0];
      OP_NOT:  result = ~in_data[WIDTH-1:0];
      default: result = 'x;
    endcase
  end

  // An accept takes priority. A simultaneous consume and accept therefore
  // replaces the result and keeps out_valid high. A consume alone drops
  // out_valid and leaves the data as it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_all   <= 1'b0;
      out_any   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_all   <= &result;
      out_any   <= |result;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LOGIC_GATE_PIPE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (count_clr) begin
      xfer_count <= '0;
    end else if (consume && (xfer_count != '1)) begin
      xfer_count <= xfer_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
module tb_logic_gate_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Default shape: WIDTH=8, NUM_IN=2 (counter narrowed so saturation is quick)
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_all, a_out_any;
  logic [15:0] a_in_data;
  logic [2:0]  a_in_op;
  logic [7:0]  a_out_data;
  logic        a_count_clr;
  logic [3:0]  a_xfer_count;

  // WIDTH=1, NUM_IN=2
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_all, b_out_any;
  logic [1:0]  b_in_data;
  logic [2:0]  b_in_op;
  logic [0:0]  b_out_data;
  logic        b_count_clr;
  logic [15:0] b_xfer_count;

  // WIDTH=8, NUM_IN=4
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_all, c_out_any;
  logic [31:0] c_in_data;
  logic [2:0]  c_in_op;
  logic [7:0]  c_out_data;
  logic        c_count_clr;
  logic [15:0] c_xfer_count;

  logic_gate_pipe #(.WIDTH(8), .NUM_IN(2), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_op(a_in_op),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_all(a_out_all), .out_any(a_out_any)
`ifdef LOGIC_GATE_PIPE_STATS_EN
    , .count_clr(a_count_clr), .xfer_count(a_xfer_count)
`endif
  );

  logic_gate_pipe #(.WIDTH(1), .NUM_IN(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_op(b_in_op),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_all(b_out_all), .out_any(b_out_any)
`ifdef LOGIC_GATE_PIPE_STATS_EN
    , .count_clr(b_count_clr), .xfer_count(b_xfer_count)
`endif
  );

  logic_gate_pipe #(.WIDTH(8), .NUM_IN(4)) u_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_op(c_in_op),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_all(c_out_all), .out_any(c_out_any)
`ifdef LOGIC_GATE_PIPE_STATS_EN
    , .count_clr(c_count_clr), .xfer_count(c_xfer_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_ops [8];
  logic [1:0] tt_in;

  initial begin
    exp_ops = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hF0, 8'h0F};
    a_in_valid = 0; a_in_data = '0; a_in_op = '0; a_out_ready = 1; a_count_clr = 0;
    b_in_valid = 0; b_in_data = '0; b_in_op = '0; b_out_ready = 1; b_count_clr = 0;
    c_in_valid = 0; c_in_data = '0; c_in_op = '0; c_out_ready = 1; c_count_clr = 0;

    // Reset state
    step(); step();
    check("rst_valid", a_out_valid, 0);
    check("rst_data",  a_out_data, 0);
    check("rst_all",   a_out_all, 0);
    check("rst_any",   a_out_any, 0);
    check("rst_ready", a_in_ready, 1);
    rst_n = 1;
    step();

    // All op codes on operand 0 = F0 and operand 1 = 3C
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1;
      a_in_data  = {8'h3C, 8'hF0};
      a_in_op    = 3'(i);
      step();
      check($sformatf("op%0d_data", i), a_out_data, exp_ops[i]);
      check($sformatf("op%0d_valid", i), a_out_valid, 1);
      check($sformatf("op%0d_any", i), a_out_any, 1);
      check($sformatf("op%0d_all", i), a_out_all, 0);
    end
    a_in_valid = 0;
    step();
    check("drain_valid", a_out_valid, 0);
    check("drain_hold", a_out_data, 8'h0F);

    // 1-bit AND truth table: in_data = {b, a}
    for (int i = 0; i < 4; i++) begin
      tt_in      = 2'(i);
      b_in_valid = 1;
      b_in_op    = 3'd0;
      b_in_data  = tt_in;
      step();
      check($sformatf("tt%0d_data", i), b_out_data, (i == 3) ? 1 : 0);
      check($sformatf("tt%0d_all", i), b_out_all, (i == 3) ? 1 : 0);
    end
    b_in_valid = 0;

    // Backpressure
    a_in_valid = 1; a_in_data = {8'hFF, 8'hFF}; a_in_op = 3'd0; a_out_ready = 1;
    step();
    check("bp_first", a_out_data, 8'hFF);
    a_out_ready = 0;
    a_in_data = {8'h0F, 8'h55}; a_in_op = 3'd1;
    #1;
    check("bp_ready_low", a_in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp_hold%0d_data", i), a_out_data, 8'hFF);
      check($sformatf("bp_hold%0d_all", i), a_out_all, 1);
      check($sformatf("bp_hold%0d_valid", i), a_out_valid, 1);
      check($sformatf("bp_hold%0d_ready", i), a_in_ready, 0);
    end
    a_out_ready = 1;
    #1;
    check("bp_release_ready", a_in_ready, 1);
    step();
    check("bp_next_data", a_out_data, 8'h5F);
    check("bp_next_valid", a_out_valid, 1);
    check("bp_next_all", a_out_all, 0);

    // Back-to-back: operand0 = i, operand1 = A5, XOR
    for (int i = 0; i < 10; i++) begin
      a_in_valid = 1;
      a_in_op    = 3'd2;
      a_in_data  = {8'hA5, 8'(i)};
      step();
      check($sformatf("b2b%0d_data", i), a_out_data, 8'(i) ^ 8'hA5);
      check($sformatf("b2b%0d_valid", i), a_out_valid, 1);
    end
    a_in_valid = 0;
    step();
    check("b2b_end_valid", a_out_valid, 0);
    check("b2b_end_hold", a_out_data, 8'hAC);

    // NUM_IN=4: operands 01, 02, 04, 08
    c_in_valid = 1; c_in_data = {8'h08, 8'h04, 8'h02, 8'h01}; c_in_op = 3'd2;
    step();
    check("n4_xor", c_out_data, 8'h0F);
    c_in_op = 3'd4;
    step();
    check("n4_nor", c_out_data, 8'hF0);
    check("n4_nor_any", c_out_any, 1);
    c_in_op = 3'd6;
    step();
    check("n4_buf", c_out_data, 8'h01);
    c_in_valid = 0;

    // Reset asserted between edges while stalled
    a_in_valid = 1; a_in_data = {8'hFF, 8'hFF}; a_in_op = 3'd0; a_out_ready = 1;
    step();
    a_out_ready = 0; a_in_valid = 0;
    step();
    check("rs_pre_valid", a_out_valid, 1);
    #2;
    rst_n = 0;
    #1;
    check("rs_valid", a_out_valid, 0);
    check("rs_data", a_out_data, 0);
    check("rs_all", a_out_all, 0);
    step();
    rst_n = 1;
    a_out_ready = 1;
    step();

`ifdef LOGIC_GATE_PIPE_STATS_EN
    check("cnt_rst", a_xfer_count, 0);
    a_in_valid = 1; a_in_data = {8'h01, 8'h02}; a_in_op = 3'd1;
    for (int i = 0; i < 20; i++) step();
    check("cnt_sat", a_xfer_count, 4'hF);
    a_count_clr = 1;
    step();
    check("cnt_clr", a_xfer_count, 0);
    a_count_clr = 0;
    a_in_valid = 0;
    step();
    check("cnt_inc", a_xfer_count, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
